// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 11011 detector: takes words over a
// valid/ready handshake and shifts them out one bit per enabled cycle.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             ser_en,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic [CNT_W-1:0] word_count
);

  localparam int BCW     = $clog2(WIDTH);
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [BCW-1:0]   bitcnt_q;
  logic             word_done_q;
  logic [CNT_W-1:0] word_count_q;
  logic             consume;
  logic             last_bit;

  assign consume    = (state_q == SHIFT) && ser_en;
  assign last_bit   = consume && (bitcnt_q == BCW'(WIDTH - 1));
  assign load_ready = (state_q == IDLE) || last_bit;

  // Shift toward whichever end feeds ser_bit, zero-filling behind.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_d = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign ser_valid  = (state_q == SHIFT);
  assign ser_bit    = ser_valid & shift_q[OUT_IDX];
  assign word_done  = word_done_q;
  assign word_count = word_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      word_done_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      word_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            shift_q  <= load_data;
            bitcnt_q <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            if (last_bit) begin
              word_done_q  <= 1'b1;
              word_count_q <= word_count_q + CNT_W'(1);
              bitcnt_q     <= '0;
              // A word offered on the last-bit cycle follows with no gap.
              if (load_valid) begin
                shift_q <= load_data;
              end else begin
                shift_q <= shift_d;
                state_q <= IDLE;
              end
            end else begin
              shift_q  <= shift_d;
              bitcnt_q <= bitcnt_q + BCW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a bit-queue reference model.
module tb_serial_bit_feeder;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             ser_en;
  logic             loadReadyM, serBitM, serValidM, wordDoneM;
  logic             loadReadyL, serBitL, serValidL, wordDoneL;
  logic [CNT_W-1:0] wordCountM, wordCountL;

  int compared = 0;
  int mismatched = 0;

  bit qM[$];
  bit qL[$];
  int modelCount;
  bit modelDone;
  logic [15:0] capM, capL;

  serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) dutM (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(loadReadyM), .ser_en(ser_en), .ser_bit(serBitM),
    .ser_valid(serValidM), .word_done(wordDoneM), .word_count(wordCountM));

  serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) dutL (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(loadReadyL), .ser_en(ser_en), .ser_bit(serBitL),
    .ser_valid(serValidL), .word_done(wordDoneL), .word_count(wordCountL));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Compare every output against the model state as it stands before the edge.
  task automatic checkOutput();
    bit expValid, expBitM, expBitL, expReady;
    expValid = (qM.size() > 0);
    expBitM  = expValid ? qM[0] : 1'b0;
    expBitL  = expValid ? qL[0] : 1'b0;
    expReady = (qM.size() == 0) || (qM.size() == 1 && ser_en);
    check("ser_valid_msb", 16'(serValidM), 16'(expValid));
    check("ser_valid_lsb", 16'(serValidL), 16'(expValid));
    check("ser_bit_msb", 16'(serBitM), 16'(expBitM));
    check("ser_bit_lsb", 16'(serBitL), 16'(expBitL));
    check("load_ready_msb", 16'(loadReadyM), 16'(expReady));
    check("load_ready_lsb", 16'(loadReadyL), 16'(expReady));
    check("word_done", 16'(wordDoneM), 16'(modelDone));
    check("word_count", 16'(wordCountM), 16'(modelCount));
    check("word_count_lsb", 16'(wordCountL), 16'(modelCount));
    if (serValidM && ser_en) capM = {capM[14:0], serBitM};
    if (serValidL && ser_en) capL = {capL[14:0], serBitL};
  endtask

  task automatic modelStep();
    bit rdy;
    rdy = (qM.size() == 0) || (qM.size() == 1 && ser_en);
    if (rst) begin
      qM.delete();
      qL.delete();
      modelCount = 0;
      modelDone  = 1'b0;
    end else begin
      modelDone = 1'b0;
      if (qM.size() > 0 && ser_en) begin
        void'(qM.pop_front());
        void'(qL.pop_front());
        if (qM.size() == 0) begin
          modelDone  = 1'b1;
          modelCount = (modelCount + 1) % (1 << CNT_W);
        end
      end
      if (rdy && load_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          qM.push_back(load_data[WIDTH-1-i]);
          qL.push_back(load_data[i]);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lv, input logic [WIDTH-1:0] ld,
                               input logic en);
    @(negedge clk);
    rst        = r;
    load_valid = lv;
    load_data  = ld;
    ser_en     = en;
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; ser_en = 1'b0;
    modelCount = 0; modelDone = 1'b0; capM = '0; capL = '0;
    @(posedge clk);
    modelStep();

    $display("[TB] reset with load offered");
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] single word 0xD8");
    capM = '0; capL = '0;
    applyStimulus(1'b0, 1'b1, 8'hD8, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check("d8_msb_bits", capM & 16'h00FF, 16'h00D8);
    check("d8_lsb_bits", capL & 16'h00FF, 16'h001B);

    $display("[TB] stall after second bit");
    capM = '0;
    applyStimulus(1'b0, 1'b1, 8'hD8, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check("stall_bits", capM & 16'h00FF, 16'h00D8);
    check("stall_count", 16'(wordCountM), 16'd2);

    $display("[TB] back-to-back words");
    capM = '0; capL = '0;
    applyStimulus(1'b0, 1'b1, 8'hDB, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'hDB, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hD8, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check("b2b_msb_bits", capM, 16'hDBD8);
    check("b2b_lsb_bits", capL, 16'hDB1B);
    check("b2b_count", 16'(wordCountM), 16'd4);

    $display("[TB] mid-word reset");
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check("midreset_count", 16'(wordCountM), 16'd0);

    $display("[TB] 256 back-to-back words");
    for (int w = 0; w < 256; w++) begin
      applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'($urandom), 8'($urandom), 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check("wrap_count", 16'(wordCountM), 16'd0);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0),
                    8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
